// File: rtl/rs_issue_queue_if.sv
// Shared packet types and the dispatch/issue port bundle of the reservation station.
package rs_pkg;
  localparam int RS_ENTRIES = 4;
  localparam int NUM_PREGS  = 64;
  localparam int P          = $clog2(NUM_PREGS);

  typedef struct packed {
    logic          instr_valid;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [P-1:0]  dst_preg;
    logic [P-1:0]  src1_preg;
    logic [P-1:0]  src2_preg;
  } disp_packet_t;

  typedef struct packed {
    disp_packet_t  disp;
    logic [31:0]   src1_val;
    logic [31:0]   src2_val;
  } exec_packet_t;
endpackage

// Handshakes: a transfer happens on a clock edge where the producer's valid
// (disp_pkt_i.instr_valid / issue_valid_o) and the consumer's ready
// (disp_ready_o / issue_ready_i) are both high; a valid payload is held
// stable until accepted, and ready never depends on valid in the same cycle.
interface rs_issue_queue_if;
  rs_pkg::disp_packet_t disp_pkt_i;
  logic                 disp_src1_rdy_i;
  logic                 disp_src2_rdy_i;
  logic                 disp_ready_o;
  rs_pkg::exec_packet_t issue_pkt_o;
  logic                 issue_valid_o;
  logic                 issue_ready_i;

  modport slave (
    input  disp_pkt_i, disp_src1_rdy_i, disp_src2_rdy_i, issue_ready_i,
    output disp_ready_o, issue_pkt_o, issue_valid_o
  );

  modport master (
    output disp_pkt_i, disp_src1_rdy_i, disp_src2_rdy_i, issue_ready_i,
    input  disp_ready_o, issue_pkt_o, issue_valid_o
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched ops until both sources are ready,
// picks the oldest eligible entry, reads/forwards operands and issues a registered packet.
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int RS_ENTRIES = rs_pkg::RS_ENTRIES,
  parameter int NUM_PREGS  = rs_pkg::NUM_PREGS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rs_issue_queue_if.slave               io,
  input  logic                          cdb_valid_i,
  input  logic [$clog2(NUM_PREGS)-1:0]  cdb_preg_i,
  input  logic [31:0]                   cdb_val_i,
  output logic [$clog2(NUM_PREGS)-1:0]  prf_raddr1_o,
  output logic [$clog2(NUM_PREGS)-1:0]  prf_raddr2_o,
  input  logic [31:0]                   prf_rdata1_i,
  input  logic [31:0]                   prf_rdata2_i,
  input  logic                          flush_i
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int IW = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0] valid_q;
  logic [RS_ENTRIES-1:0] rdy1_q;
  logic [RS_ENTRIES-1:0] rdy2_q;
  disp_packet_t          ent_q   [RS_ENTRIES];
  // older_q[i][j] = 1: entry i was dispatched before entry j.
  logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];

  exec_packet_t          issue_pkt_q;
  logic                  issue_valid_q;

  logic [RS_ENTRIES-1:0] hit1, hit2, elig, pick_oh;
  logic                  have_pick;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         free_idx;
  logic                  disp_ready, disp_accept, issue_fire;
  logic                  dsp_hit1, dsp_hit2;
  disp_packet_t          pick_ent;
  logic [31:0]           op1, op2;
  exec_packet_t          issue_next;

  // CDB tag match per entry; a same-cycle match already counts as ready.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int e = 0; e < RS_ENTRIES; e++) begin
      hit1[e] = cdb_valid_i && (cdb_preg_i == ent_q[e].src1_preg);
      hit2[e] = cdb_valid_i && (cdb_preg_i == ent_q[e].src2_preg);
    end
    elig = valid_q & (rdy1_q | hit1) & (rdy2_q | hit2);
  end

  // Oldest-first select: an eligible entry wins if no eligible entry is older.
  always_comb begin
    pick_oh = '0;
    for (int e = 0; e < RS_ENTRIES; e++) begin
      pick_oh[e] = elig[e];
      for (int k = 0; k < RS_ENTRIES; k++) begin
        if (elig[k] && older_q[k][e]) pick_oh[e] = 1'b0;
      end
    end
  end

  always_comb begin
    pick_idx  = '0;
    have_pick = |pick_oh;
    for (int e = 0; e < RS_ENTRIES; e++) begin
      if (pick_oh[e]) pick_idx = IW'(e);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
      if (!valid_q[e]) free_idx = IW'(e);
    end
  end

  // Occupancy check uses registered valid bits only, so a slot freed by
  // this cycle's issue becomes usable one cycle later.
  assign disp_ready  = ~&valid_q;
  assign disp_accept = io.disp_pkt_i.instr_valid && disp_ready && !flush_i;
  assign issue_fire  = have_pick && (!issue_valid_q || io.issue_ready_i) && !flush_i;

  assign dsp_hit1 = cdb_valid_i && (cdb_preg_i == io.disp_pkt_i.src1_preg);
  assign dsp_hit2 = cdb_valid_i && (cdb_preg_i == io.disp_pkt_i.src2_preg);

  // Operand mux: forward the CDB value on a tag match, else use the PRF read.
  always_comb begin
    pick_ent     = ent_q[pick_idx];
    prf_raddr1_o = have_pick ? pick_ent.src1_preg : PW'(0);
    prf_raddr2_o = have_pick ? pick_ent.src2_preg : PW'(0);
    op1          = hit1[pick_idx] ? cdb_val_i : prf_rdata1_i;
    op2          = hit2[pick_idx] ? cdb_val_i : prf_rdata2_i;
    issue_next          = '0;
    issue_next.disp     = pick_ent;
    issue_next.src1_val = op1;
    issue_next.src2_val = op2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      issue_pkt_q   <= '0;
      issue_valid_q <= 1'b0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
        ent_q[e]   <= '0;
        older_q[e] <= '0;
      end
    end else if (flush_i) begin
      valid_q       <= '0;
      issue_valid_q <= 1'b0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
        older_q[e] <= '0;
      end
    end else begin
      rdy1_q <= rdy1_q | hit1;
      rdy2_q <= rdy2_q | hit2;

      if (issue_fire) begin
        valid_q[pick_idx] <= 1'b0;
        issue_pkt_q       <= issue_next;
        issue_valid_q     <= 1'b1;
      end else if (io.issue_ready_i) begin
        issue_valid_q <= 1'b0;
      end

      // The free slot is never the picked one, so dispatch and issue do not collide.
      if (disp_accept) begin
        valid_q[free_idx] <= 1'b1;
        ent_q[free_idx]   <= io.disp_pkt_i;
        rdy1_q[free_idx]  <= io.disp_src1_rdy_i | dsp_hit1;
        rdy2_q[free_idx]  <= io.disp_src2_rdy_i | dsp_hit2;
        older_q[free_idx] <= '0;
        for (int k = 0; k < RS_ENTRIES; k++) begin
          older_q[k][free_idx] <= valid_q[k];
        end
      end
    end
  end

  assign io.disp_ready_o  = disp_ready;
  assign io.issue_pkt_o   = issue_pkt_q;
  assign io.issue_valid_o = issue_valid_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: expected issue packets go into a queue,
// a negedge monitor pops and compares each accepted issue.
module tb_rs_issue_queue;
  import rs_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cdb_valid;
  logic [5:0]  cdb_preg;
  logic [31:0] cdb_val;
  logic [5:0]  prf_raddr1, prf_raddr2;
  logic [31:0] prf_rdata1, prf_rdata2;
  logic        flush;
  logic [31:0] prf [64];

  int errors = 0;
  int checks = 0;
  logic [146:0] exp_q[$];

  rs_issue_queue_if bus ();

  rs_issue_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (bus),
    .cdb_valid_i  (cdb_valid),
    .cdb_preg_i   (cdb_preg),
    .cdb_val_i    (cdb_val),
    .prf_raddr1_o (prf_raddr1),
    .prf_raddr2_o (prf_raddr2),
    .prf_rdata1_i (prf_rdata1),
    .prf_rdata2_i (prf_rdata2),
    .flush_i      (flush)
  );

  assign prf_rdata1 = prf[prf_raddr1];
  assign prf_rdata2 = prf[prf_raddr2];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Helpers
  function automatic disp_packet_t mk_disp(input int dst, input int s1, input int s2, input int pc);
    disp_packet_t d;
    d.instr_valid = 1'b1;
    d.pc          = 32'(pc);
    d.imm         = 32'(32'h1000 + dst);
    d.dst_preg    = 6'(dst);
    d.src1_preg   = 6'(s1);
    d.src2_preg   = 6'(s2);
    return d;
  endfunction

  function automatic logic [146:0] mk_exec(input disp_packet_t d, input int v1, input int v2);
    exec_packet_t e;
    e.disp     = d;
    e.src1_val = 32'(v1);
    e.src2_val = 32'(v2);
    return e;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_pkt(input string name, input logic [146:0] got, input logic [146:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int dst, input int s1, input int s2, input int pc,
                       input logic r1, input logic r2);
    bus.disp_pkt_i      = mk_disp(dst, s1, s2, pc);
    bus.disp_src1_rdy_i = r1;
    bus.disp_src2_rdy_i = r2;
  endtask

  task automatic idle_disp();
    bus.disp_pkt_i      = '0;
    bus.disp_src1_rdy_i = 1'b0;
    bus.disp_src2_rdy_i = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid_o && bus.issue_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h expected none", bus.issue_pkt_o);
      end else begin
        check_pkt("issue_pkt", bus.issue_pkt_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) prf[i] = 32'(i * 10);
    rst_n             = 1'b0;
    flush             = 1'b0;
    cdb_valid         = 1'b0;
    cdb_preg          = '0;
    cdb_val           = '0;
    bus.issue_ready_i = 1'b1;
    idle_disp();
    repeat (3) tick();
    check_bit("rst_issue_valid", bus.issue_valid_o, 1'b0);
    check_pkt("rst_issue_pkt", bus.issue_pkt_o, '0);
    rst_n = 1'b1;
    tick();
    check_bit("rst_disp_ready", bus.disp_ready_o, 1'b1);

    // T1: both sources ready, issue two cycles after dispatch
    offer(5, 1, 2, 32'h100, 1'b1, 1'b1);
    exp_q.push_back(mk_exec(mk_disp(5, 1, 2, 32'h100), 10, 20));
    tick();
    idle_disp();
    check_bit("t1_lat_n1", bus.issue_valid_o, 1'b0);
    tick();
    check_bit("t1_lat_n2", bus.issue_valid_o, 1'b1);
    tick();

    // T2: waiting A overtaken by ready B; A woken by CDB with forwarding
    offer(10, 7, 3, 32'h200, 1'b0, 1'b1);
    tick();
    offer(11, 4, 5, 32'h204, 1'b1, 1'b1);
    exp_q.push_back(mk_exec(mk_disp(11, 4, 5, 32'h204), 40, 50));
    tick();
    idle_disp();
    repeat (3) tick();
    check_bit("t2_a_waits", bus.issue_valid_o, 1'b0);
    cdb_valid = 1'b1;
    cdb_preg  = 6'd7;
    cdb_val   = 32'hDEAD;
    exp_q.push_back(mk_exec(mk_disp(10, 7, 3, 32'h200), 32'hDEAD, 30));
    tick();
    cdb_valid = 1'b0;
    check_bit("t2_wakeup_lat", bus.issue_valid_o, 1'b1);
    tick();

    // T3: FU stalled, fill the station
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(20 + i, 8 + i, 12 + i, 32'h300 + 4 * i, 1'b1, 1'b1);
      exp_q.push_back(mk_exec(mk_disp(20 + i, 8 + i, 12 + i, 32'h300 + 4 * i),
                              (8 + i) * 10, (12 + i) * 10));
      tick();
    end
    idle_disp();
    check_bit("t3_three_left", bus.disp_ready_o, 1'b1);
    check_bit("t3_held_valid", bus.issue_valid_o, 1'b1);
    check_pkt("t3_held_pkt", bus.issue_pkt_o, mk_exec(mk_disp(20, 8, 12, 32'h300), 80, 120));
    offer(24, 12, 16, 32'h310, 1'b1, 1'b1);
    exp_q.push_back(mk_exec(mk_disp(24, 12, 16, 32'h310), 120, 160));
    tick();
    offer(25, 15, 17, 32'h314, 1'b1, 1'b1);
    check_bit("t3_full", bus.disp_ready_o, 1'b0);
    tick();
    check_bit("t3_full_hold", bus.disp_ready_o, 1'b0);

    // T4: FU resumes while full and a packet is offered
    bus.issue_ready_i = 1'b1;
    exp_q.push_back(mk_exec(mk_disp(25, 15, 17, 32'h314), 150, 170));
    tick();
    check_bit("t4_slot_free", bus.disp_ready_o, 1'b1);
    tick();
    idle_disp();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check_bit("t4_drained", exp_q.size() == 0, 1'b1);
    tick();
    check_bit("t4_idle", bus.issue_valid_o, 1'b0);

    // T5: CDB match on the packet being dispatched
    offer(30, 1, 9, 32'h400, 1'b1, 1'b0);
    cdb_valid = 1'b1;
    cdb_preg  = 6'd9;
    cdb_val   = 32'h99;
    prf[9]    = 32'h99;
    exp_q.push_back(mk_exec(mk_disp(30, 1, 9, 32'h400), 10, 32'h99));
    tick();
    idle_disp();
    cdb_valid = 1'b0;
    check_bit("t5_lat_n1", bus.issue_valid_o, 1'b0);
    tick();
    check_bit("t5_lat_n2", bus.issue_valid_o, 1'b1);
    tick();

    // T6: flush with three entries queued and an output held
    bus.issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(40 + i, 1, 2, 32'h500 + 4 * i, 1'b1, 1'b1);
      tick();
    end
    idle_disp();
    check_bit("t6_held", bus.issue_valid_o, 1'b1);
    flush = 1'b1;
    offer(50, 1, 2, 32'h600, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    idle_disp();
    check_bit("t6_flush_valid", bus.issue_valid_o, 1'b0);
    check_bit("t6_flush_ready", bus.disp_ready_o, 1'b1);
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_bit("t6_no_issue", bus.issue_valid_o, 1'b0);
    end

    check_bit("final_queue_empty", exp_q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
